// File: rtl/spi_master_if.sv
// SPI master bus: frame handshake towards the host plus the four SPI pins.
interface spi_master_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              cs_n;

  modport master (
    input  tx_data, tx_last, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );

  modport slave (
    output tx_data, tx_last, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_W-bit frame per handshake, MSB first, with
// optional chip-select hold across frames (tx_last=0).
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master spi
);
  localparam int unsigned      BIT_W   = $clog2(DATA_W + 1);
  localparam logic [7:0]       DIV_END = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_END = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t            state, state_d;
  logic [7:0]        div_cnt, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d;
  logic [DATA_W-1:0] rx_sh, rx_sh_d;
  logic [DATA_W-1:0] rx_data, rx_data_d;
  logic              last, last_d;
  logic              sclk, sclk_d;
  logic              mosi, mosi_d;
  logic              cs_n, cs_n_d;
  logic              tx_ready, tx_ready_d;
  logic              rx_valid, rx_valid_d;
  logic              accept;
  logic              div_end;

  assign accept  = spi.tx_valid && tx_ready;
  assign div_end = (div_cnt == DIV_END);

  always_comb begin
    state_d    = state;
    div_cnt_d  = div_cnt;
    bit_cnt_d  = bit_cnt;
    tx_sh_d    = tx_sh;
    rx_sh_d    = rx_sh;
    rx_data_d  = rx_data;
    last_d     = last;
    sclk_d     = sclk;
    mosi_d     = mosi;
    cs_n_d     = cs_n;
    rx_valid_d = 1'b0;
    unique case (state)
      IDLE, WAIT: begin
        if (accept) begin
          state_d   = SETUP;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          tx_sh_d   = spi.tx_data;
          last_d    = spi.tx_last;
          mosi_d    = spi.tx_data[DATA_W-1];
          cs_n_d    = 1'b0;
        end
      end
      // SETUP is the first low half-period; both states share the edge logic.
      SETUP, SHIFT: begin
        if (!div_end) begin
          div_cnt_d = div_cnt + 8'd1;
        end else begin
          div_cnt_d = '0;
          if (!sclk) begin
            state_d = SHIFT;
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh[DATA_W-2:0], spi.miso};
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_END) begin
              rx_data_d  = rx_sh;
              rx_valid_d = 1'b1;
              state_d    = last ? HOLD : WAIT;
            end else begin
              tx_sh_d = {tx_sh[DATA_W-2:0], 1'b0};
              mosi_d  = tx_sh[DATA_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          div_cnt_d = '0;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          state_d   = GAP;
        end else begin
          div_cnt_d = div_cnt + 8'd1;
        end
      end
      GAP: begin
        if (div_end) begin
          div_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_ready_d = (state_d == IDLE) || (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      last     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      tx_sh    <= tx_sh_d;
      rx_sh    <= rx_sh_d;
      rx_data  <= rx_data_d;
      last     <= last_d;
      sclk     <= sclk_d;
      mosi     <= mosi_d;
      cs_n     <= cs_n_d;
      tx_ready <= tx_ready_d;
      rx_valid <= rx_valid_d;
    end
  end

  assign spi.tx_ready = tx_ready;
  assign spi.rx_data  = rx_data;
  assign spi.rx_valid = rx_valid;
  assign spi.busy     = (state != IDLE);
  assign spi.sclk     = sclk;
  assign spi.mosi     = mosi;
  assign spi.cs_n     = cs_n;
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: an SPI slave model plus frame-level timing
// expectations, with a second instance exercising the CLK_DIV=1 corner.
module tb_spi_master;
  localparam int unsigned DW = 8;
  localparam int unsigned CD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(DW)) spi ();
  spi_master_if #(.DATA_W(DW)) spi1 ();

  spi_master #(.DATA_W(DW), .CLK_DIV(CD)) u_dut  (.clk(clk), .rst_n(rst_n), .spi(spi));
  spi_master #(.DATA_W(DW), .CLK_DIV(1))  u_div1 (.clk(clk), .rst_n(rst_n), .spi(spi1));

  int compared = 0;
  int mismatched = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues, filled by the stimulus side.
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] exp_rx_q[$];
  logic [DW-1:0] exp_cap_q[$];
  int unsigned   t_q[$];

  // SPI slave: shifts out the front response word, captures mosi on sclk rise.
  logic          loop = 1'b1;
  logic          slave_bit = 1'b0;
  int unsigned   sl_n = 0;
  logic [DW-1:0] sl_cap = '0;
  assign spi.miso = loop ? spi.mosi : slave_bit;

  always @(negedge clk) begin
    logic [DW-1:0] w;
    w = (resp_q.size() > 0) ? resp_q[0] : '0;
    slave_bit = w[DW-1-sl_n];
  end

  always @(posedge spi.sclk or posedge spi.cs_n) begin
    if (spi.cs_n) begin
      if (sl_n != 0) begin
        sl_n = 0;
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        if (exp_cap_q.size() > 0) void'(exp_cap_q.pop_front());
      end
    end else begin
      sl_cap = {sl_cap[DW-2:0], spi.mosi};
      sl_n++;
      if (sl_n == DW) begin
        sl_n = 0;
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        if (exp_cap_q.size() == 0) check("slave_cap_unexpected", 1, 0);
        else check("slave_cap", sl_cap, exp_cap_q.pop_front());
      end
    end
  end

  // Monitor: every rx_valid pulse pops one expected frame.
  int unsigned rxv_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rx_q.delete();
      t_q.delete();
    end else if (spi.rx_valid) begin
      rxv_cnt++;
      if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
      else begin
        check("rx_data", spi.rx_data, exp_rx_q.pop_front());
        check("rx_valid_cycle", cyc - t_q.pop_front(), 2 * DW * CD);
      end
    end
  end

  // sclk rise log and cs_n watcher.
  logic        prev_sclk = 1'b0;
  int unsigned rise_cnt = 0;
  int unsigned rise_q[$];
  logic        watch = 1'b0;
  int unsigned csn_high = 0;
  always @(negedge clk) begin
    if (spi.sclk && !prev_sclk) begin
      rise_cnt++;
      rise_q.push_back(cyc);
    end
    prev_sclk = spi.sclk;
    if (watch && spi.cs_n) csn_high++;
  end

  task automatic wait_ready();
    int unsigned i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spi.tx_ready) break;
    end
    check("ready_wait", spi.tx_ready, 1);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic lp,
                      input logic [DW-1:0] r, output int unsigned t);
    wait_ready();
    loop = lp;
    resp_q.push_back(r);
    exp_rx_q.push_back(lp ? d : r);
    exp_cap_q.push_back(d);
    spi.tx_data  = d;
    spi.tx_last  = l;
    spi.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    t_q.push_back(t);
    spi.tx_valid = 1'b0;
    spi.tx_data  = DW'($urandom);
    spi.tx_last  = 1'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int unsigned i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!spi.busy) break;
    end
    check(name, spi.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t2, n, bad, rxc, r0, v0, busy_low, i;
    logic p;
    logic [DW-1:0] d;

    spi.tx_valid  = 1'b0;
    spi.tx_data   = '0;
    spi.tx_last   = 1'b0;
    spi1.tx_valid = 1'b0;
    spi1.tx_data  = '0;
    spi1.tx_last  = 1'b0;
    spi1.miso     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi.cs_n, 1);
    check("rst_sclk", spi.sclk, 0);
    check("rst_mosi", spi.mosi, 0);
    check("rst_tx_ready", spi.tx_ready, 0);
    check("rst_rx_valid", spi.rx_valid, 0);
    check("rst_rx_data", spi.rx_data, 0);
    check("rst_busy", spi.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", spi.tx_ready, 1);

    // CLK_DIV=1 corner: 0xFF out, miso held low
    spi1.tx_data = 8'hFF; spi1.tx_last = 1'b1; spi1.tx_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    spi1.tx_valid = 1'b0;
    p = 1'b0; n = 0; bad = 0; rxc = 0;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (spi1.sclk && !p) begin
        if (cyc != t + 1 + 2 * n) bad++;
        n++;
      end
      p = spi1.sclk;
      if (spi1.rx_valid) begin
        rxc++;
        check("div1_rx_cycle", cyc - t, 16);
        check("div1_rx_data", spi1.rx_data, 0);
      end
    end
    check("div1_rises", n, 8);
    check("div1_rise_timing_errors", bad, 0);
    check("div1_rx_pulses", rxc, 1);

    // Loopback 0xA5
    rise_q.delete();
    send(8'hA5, 1'b1, 1'b1, 8'h00, t);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi.cs_n) break;
    end
    check("loop_cs_high_cycle", cyc - t, 68);
    for (i = 0; i < 100; i++) begin
      if (spi.tx_ready) break;
      @(negedge clk);
    end
    check("loop_ready_cycle", cyc - t, 72);
    check("loop_rises", rise_q.size(), 8);
    if (rise_q.size() == 8) begin
      check("loop_first_rise", rise_q[0] - t, CD);
      check("loop_last_rise", rise_q[7] - t, 15 * CD);
    end

    // Slave model: send 0xC3, slave returns 0x3C
    send(8'hC3, 1'b1, 1'b0, 8'h3C, t);
    wait_idle("slave_idle");

    // Burst: 0x12 then 0x34 with cs_n held low
    r0 = rise_cnt; v0 = rxv_cnt; csn_high = 0;
    send(8'h12, 1'b0, 1'b0, DW'($urandom), t);
    watch = 1'b1;
    send(8'h34, 1'b1, 1'b0, DW'($urandom), t);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rxv_cnt >= v0 + 2) break;
    end
    watch = 1'b0;
    check("burst_cs_high_samples", csn_high, 0);
    check("burst_rises", rise_cnt - r0, 16);
    check("burst_rx_pulses", rxv_cnt - v0, 2);
    wait_idle("burst_idle");

    // Busy: tx_valid held through the whole frame
    loop = 1'b1;
    repeat (2) begin
      resp_q.push_back('0);
      exp_rx_q.push_back(8'h5A);
      exp_cap_q.push_back(8'h5A);
    end
    spi.tx_data = 8'h5A; spi.tx_last = 1'b1; spi.tx_valid = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    t_q.push_back(t);
    busy_low = 0; t2 = 0;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spi.tx_ready) begin
        t2 = cyc + 1;
        break;
      end
      if (!spi.busy) busy_low++;
    end
    @(posedge clk); #1;
    t_q.push_back(cyc);
    spi.tx_valid = 1'b0;
    check("busy_second_accept", t2 - t, 73);
    check("busy_low_in_frame", busy_low, 0);
    wait_idle("busy_idle");

    // Reset after the third sclk rise
    r0 = rise_cnt;
    send(8'h96, 1'b1, 1'b1, 8'h00, t);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rise_cnt >= r0 + 3) break;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cs_n", spi.cs_n, 1);
    check("abort_sclk", spi.sclk, 0);
    check("abort_busy", spi.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = rise_cnt; v0 = rxv_cnt;
    repeat (100) @(negedge clk);
    check("abort_no_rx_valid", rxv_cnt - v0, 0);
    check("abort_no_rises", rise_cnt - r0, 0);

    // Randomised frames with random bursts, gaps and miso source
    for (int k = 0; k < 40; k++) begin
      d = DW'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(d, (k == 39) ? 1'b1 : ($urandom_range(0, 2) == 0), 1'($urandom),
           DW'($urandom), t);
    end
    wait_idle("random_idle");
    repeat (5) @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("cap_queue_drained", exp_cap_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the frame width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter CLK_DIV, default 4, giving the sclk half-period in clk cycles (legal range 1..255).
REQ-003 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port tx_data, input, DATA_W: frame to send, MSB first.
REQ-006 Port tx_last, input, 1: when 1, cs_n is released after this frame.
REQ-007 Port tx_valid, input, 1: tx_data and tx_last are valid.
REQ-008 Port tx_ready, output, 1: the block accepts a frame this cycle.
REQ-009 Port rx_data, output, DATA_W: frame captured from miso.
REQ-010 Port rx_valid, output, 1: one-cycle pulse; rx_data is valid.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port sclk, output, 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 Port mosi, output, 1: serial data out.
REQ-014 Port miso, input, 1: serial data in, already synchronised outside this block.
REQ-015 Port cs_n, output, 1: chip select, active-low.

Function
REQ-016 Frame acceptance SHALL occur only when tx_valid=1 and tx_ready=1; tx_data and tx_last SHALL be latched at that edge and changes after it SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, SETUP, SHIFT, WAIT, HOLD and GAP.
REQ-018 IDLE SHALL drive tx_ready=1, cs_n=1 and sclk=0; on acceptance the FSM SHALL go to SETUP and cs_n SHALL fall on the next cycle T.
REQ-019 SETUP SHALL last CLK_DIV cycles, with mosi carrying the MSB from cycle T.
REQ-020 SHIFT timing: for k=0..DATA_W-1, sclk SHALL rise at T+(2k+1)*CLK_DIV and fall at T+(2k+2)*CLK_DIV.
REQ-021 At each sclk rising edge, the miso value present at the clk edge that sets sclk to 1 SHALL be shifted into the receive register at the LSB end.
REQ-022 At each sclk falling edge except the last, mosi SHALL advance to the next lower bit.
REQ-023 At the final sclk falling edge (T+2*DATA_W*CLK_DIV), rx_data SHALL update and rx_valid SHALL be 1 for exactly that cycle.
REQ-024 After the final falling edge, if tx_last=1 the FSM SHALL go to HOLD; if tx_last=0 it SHALL go to WAIT.
REQ-025 WAIT SHALL hold cs_n=0, sclk=0 and tx_ready=1, and SHALL remain indefinitely until acceptance.
REQ-026 On acceptance in WAIT, the next frame SHALL follow REQ-019..REQ-024 with T set to the cycle after acceptance.
REQ-027 HOLD SHALL keep cs_n=0 for CLK_DIV cycles, then raise cs_n; the FSM SHALL then go to GAP.
REQ-028 GAP SHALL hold cs_n=1 and tx_ready=0 for CLK_DIV cycles, then go to IDLE.
REQ-029 tx_ready SHALL be 0 in SETUP, SHIFT, HOLD and GAP; tx_valid asserted in those states SHALL have no effect.
REQ-030 The bit counter SHALL be ceil(log2(DATA_W+1)) wide and the divider counter SHALL be 8 bits; neither SHALL wrap within a frame.
REQ-031 When CLK_DIV=1, sclk SHALL toggle every clk cycle with no dead cycles inside SHIFT.

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL be in IDLE with cs_n=1, sclk=0, mosi=0, tx_ready=0, rx_valid=0, rx_data=0 and busy=0; tx_ready SHALL become 1 on the first edge with rst_n=1.
REQ-033 A reset asserted mid-frame SHALL abort the frame at the next clk edge, with no rx_valid pulse and no further sclk edges.

Verification
REQ-034 Loopback test: miso tied to mosi, DATA_W=8, CLK_DIV=4; send 0xA5 with tx_last=1 -> 8 sclk rises, rx_data=0xA5, rx_valid at T+64, cs_n high at T+68, tx_ready at T+72.
REQ-035 Slave-model test: send 0xC3 while the slave model returns 0x3C -> rx_data=0x3C; the slave captures 0xC3.
REQ-036 Burst test: send 0x12 (tx_last=0) then 0x34 (tx_last=1) -> cs_n stays low across both frames, 16 sclk rises total, two rx_valid pulses.
REQ-037 Busy test: hold tx_valid=1 through a frame -> no second acceptance before WAIT or IDLE; busy=1 throughout the frame.
REQ-038 Reset test: pulse rst_n=0 after the 3rd sclk rise -> next cycle cs_n=1 and sclk=0; no rx_valid pulse.
REQ-039 Divider corner test: CLK_DIV=1, send 0xFF with miso=0 -> sclk period of 2 cycles, rx_data=0x00, rx_valid at T+16.
